// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a small first-word-fall-through receive FIFO.
// Serial input is double-synchronized; frames are sampled mid-bit and good
// bytes are pushed into a circular buffer read by the CPU-side register block.
module uart_rx_fifo #(
    parameter int unsigned CLOCK_FREQ = 25000000,
    parameter int unsigned BIT_RATE   = 9600,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_error,
    output logic                          overflow,
    input  logic                          clear_overflow,
    output logic                          busy
);

    localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BIT_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned AW           = $clog2(FIFO_DEPTH);
    localparam int unsigned PW           = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // Receiver state
    logic          rx_meta;
    logic          rxs;
    state_t        state;
    state_t        state_n;
    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] cnt_n;
    logic [2:0]    bit_idx;
    logic [2:0]    idx_n;
    logic [7:0]    shreg;
    logic [7:0]    shreg_n;
    logic          push_req;
    logic          ferr_n;

    // FIFO state
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;
    logic          drop;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Next-state, baud counter, shift register and push/error decisions.
    always_comb begin
        state_n  = state;
        cnt_n    = bit_cnt + 1'b1;
        idx_n    = bit_idx;
        shreg_n  = shreg;
        push_req = 1'b0;
        ferr_n   = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (!rxs) begin
                    state_n = S_START;
                end
            end
            S_START: begin
                if (bit_cnt == CW'(HALF_BIT - 1)) begin
                    cnt_n = '0;
                    if (!rxs) begin
                        state_n = S_DATA;
                        idx_n   = '0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (bit_cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_n   = '0;
                    shreg_n = {rxs, shreg[7:1]};
                    idx_n   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (bit_cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_n = '0;
                    if (rxs) begin
                        push_req = 1'b1;
                        state_n  = S_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A held-low line must return high before a new start is accepted.
                cnt_n = '0;
                if (rxs) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= cnt_n;
            bit_idx     <= idx_n;
            shreg       <= shreg_n;
            frame_error <= ferr_n;
        end
    end

    assign busy = (state != S_IDLE);

    // A pop frees the full slot in the same cycle, so push-while-full is
    // accepted when it coincides with a pop; the write lands in the slot
    // being vacated.
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == PW'(FIFO_DEPTH));
    assign do_pop  = rd_en && !empty;
    assign do_push = push_req && (!full || do_pop);
    assign drop    = push_req && full && !do_pop;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // FIFO storage and pointers; reset flushes contents so rd_data reads zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            mem    <= '{default: '0};
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= shreg;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a byte scoreboard (16 clocks per bit).
module tb_uart_rx_fifo;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       frame_error;
    logic       overflow;
    logic       clear_overflow;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int fe_long = 0;
    logic fe_prev = 1'b0;
    int busy_low = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovf = 1'b0;

    uart_rx_fifo #(
        .CLOCK_FREQ(160),
        .BIT_RATE  (10),
        .FIFO_DEPTH(4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .empty         (empty),
        .full          (full),
        .count         (count),
        .frame_error   (frame_error),
        .overflow      (overflow),
        .clear_overflow(clear_overflow),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_error === 1'b1) fe_cnt++;
        if (frame_error === 1'b1 && fe_prev === 1'b1) fe_long++;
        fe_prev = frame_error;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 8N1 frame; optionally pops the head in the cycle the byte is pushed,
    // then optionally holds the line low after the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic pop_at_push, input int extra_low);
        for (int i = 0; i < 10 * CPB; i++) begin
            int bt;
            bt = i / CPB;
            if (bt == 0) rx = 1'b0;
            else if (bt <= 8) rx = b[bt-1];
            else rx = stop;
            rd_en = 1'b0;
            if (pop_at_push && i == 10 * CPB - 6) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $error("FAIL sb_underflow observed=empty expected=data");
                end else begin
                    chk("pop_at_push_head", rd_data, exp_q.pop_front());
                end
                rd_en = 1'b1;
            end
            tick;
        end
        rd_en = 1'b0;
        for (int i = 0; i < extra_low; i++) begin
            rx = 1'b0;
            if (busy !== 1'b1) busy_low++;
            tick;
        end
        rx = 1'b1;
        repeat (4) tick;
        if (stop) begin
            if (exp_q.size() < 4) exp_q.push_back(b);
            else exp_ovf = 1'b1;
        end
    endtask

    task automatic read_check(input string tag);
        chk({tag, "_nonempty"}, empty, 0);
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s_sb_underflow observed=empty expected=data", tag);
        end else begin
            chk(tag, rd_data, exp_q.pop_front());
        end
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        rx = 1'b1;
        rd_en = 1'b0;
        clear_overflow = 1'b0;
        repeat (3) tick;
        reset = 1'b0;
        tick;

        // Reset state
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_ferr", frame_error, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_data", rd_data, 0);

        // 1: single good frame, then pop
        send_frame(8'hA5, 1'b1, 1'b0, 0);
        chk("t1_empty", empty, 0);
        chk("t1_count", count, 1);
        read_check("t1_data");
        chk("t1_empty_after", empty, 1);
        chk("t1_count_after", count, 0);

        // 2: short low glitch is rejected at the start-bit midpoint
        rx = 1'b0;
        repeat (5) tick;
        chk("t2_busy_in_glitch", busy, 1);
        rx = 1'b1;
        repeat (30) tick;
        chk("t2_busy", busy, 0);
        chk("t2_count", count, 0);
        chk("t2_ferr_cnt", fe_cnt, 0);

        // 3: bad stop bit, held-low break, then recovery
        busy_low = 0;
        send_frame(8'h3C, 1'b0, 1'b0, 40);
        chk("t3_ferr_cnt", fe_cnt, 1);
        chk("t3_ferr_width", fe_long, 0);
        chk("t3_busy_in_break", busy_low, 0);
        chk("t3_count_none", count, 0);
        send_frame(8'h11, 1'b1, 1'b0, 0);
        chk("t3_count", count, 1);
        read_check("t3_data");
        chk("t3_ferr_cnt_end", fe_cnt, 1);

        // 4: fill, overflow drop, drain, clear
        for (int v = 1; v <= 5; v++) begin
            send_frame(8'(v), 1'b1, 1'b0, 0);
            if (v == 4) begin
                chk("t4_full4", full, 1);
                chk("t4_count4", count, 4);
                chk("t4_ovf4", overflow, 0);
            end
        end
        chk("t4_ovf", overflow, exp_ovf);
        chk("t4_count5", count, 4);
        for (int v = 1; v <= 4; v++) read_check("t4_data");
        chk("t4_empty", empty, 1);
        chk("t4_ovf_sticky", overflow, 1);
        clear_overflow = 1'b1;
        tick;
        clear_overflow = 1'b0;
        exp_ovf = 1'b0;
        chk("t4_ovf_cleared", overflow, 0);

        // 5: push while full with a simultaneous pop
        for (int v = 1; v <= 4; v++) send_frame(8'(v), 1'b1, 1'b0, 0);
        chk("t5_full", full, 1);
        send_frame(8'h05, 1'b1, 1'b1, 0);
        chk("t5_count", count, 4);
        chk("t5_ovf", overflow, exp_ovf);
        for (int v = 2; v <= 5; v++) read_check("t5_data");
        chk("t5_empty", empty, 1);

        // 6: reset mid-frame flushes FIFO and abandons the frame
        send_frame(8'h55, 1'b1, 1'b0, 0);
        chk("t6_pre_count", count, 1);
        for (int i = 0; i < 5 * CPB + 8; i++) begin
            int bt;
            bt = i / CPB;
            rx = (bt == 0) ? 1'b0 : ((8'h96 >> (bt - 1)) & 1);
            tick;
        end
        chk("t6_busy_pre", busy, 1);
        reset = 1'b1;
        rx = 1'b1;
        tick;
        reset = 1'b0;
        exp_q.delete();
        chk("t6_busy", busy, 0);
        chk("t6_empty", empty, 1);
        chk("t6_count", count, 0);
        chk("t6_rd_data", rd_data, 0);
        repeat (4) tick;
        send_frame(8'h7E, 1'b1, 1'b0, 0);
        chk("t6_count_after", count, 1);
        read_check("t6_data");
        chk("t6_empty_end", empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
